iob_regarray_mp: RTL and testbench

Parametrised multi-read-port register array with byte-strobed writes, optional registered reads with write-to-read forwarding, and a self-timed clear sweep. It is the general-purpose storage primitive for small tables in cache and controller blocks (tag/valid shadows, descriptor slots) that need more than one simultaneous lookup and a bulk invalidate without a reset.

---
 rtl/iob_regarray_mp.sv | 105 ++++++++++
 tb/tb_iob_regarray_mp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_regarray_mp.sv
// Multi-read-port register array with byte-strobed writes, optional registered
// reads with write forwarding, and a self-timed clear sweep.
module iob_regarray_mp #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_RD   = 2,
    parameter bit          RD_REG = 1'b1,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   cke_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [DATA_W/8-1:0]    wstrb_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [N_RD*ADDR_W-1:0] raddr_i,
    output logic [N_RD*DATA_W-1:0] rdata_o,
    input  logic                   clear_i,
    output logic                   busy_o
);
    localparam int unsigned Depth  = 2 ** ADDR_W;
    localparam int unsigned NBytes = DATA_W / 8;

    typedef enum logic {StIdle, StSweep} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] mem_d [Depth];
    logic              wr_acc;
    logic [DATA_W-1:0] wmerged;

    assign busy_o = (state_q == StSweep);
    // cke_i is applied at the registers, so this only reflects the busy gate
    assign wr_acc = we_i && !busy_o;

    always_comb begin
        wmerged = mem_q[waddr_i];
        for (int b = 0; b < NBytes; b++) begin
            if (wstrb_i[b]) wmerged[b*8 +: 8] = wdata_i[b*8 +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        if (wr_acc) mem_d[waddr_i] = wmerged;
        case (state_q)
            StIdle: begin
                if (clear_i) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            StSweep: begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + ADDR_W'(1);
                if (&cnt_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr_i[p*ADDR_W +: ADDR_W];

        if (RD_REG) begin : g_reg
            logic [DATA_W-1:0] rd_q, rd_d;

            // Forward only accepted writes; sweep zeros are never forwarded
            always_comb begin
                rd_d = mem_q[ra];
                if (BYPASS && wr_acc && (waddr_i == ra)) rd_d = wmerged;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_q <= '0;
                end else if (cke_i) begin
                    rd_q <= rd_d;
                end
            end

            assign rdata_o[p*DATA_W +: DATA_W] = rd_q;
        end else begin : g_comb
            assign rdata_o[p*DATA_W +: DATA_W] = mem_q[ra];
        end
    end

endmodule

// File: tb/tb_iob_regarray_mp.sv
// Bench for iob_regarray_mp: bypass, no-bypass and combinational-read instances
// share stimulus and are checked against an abstract array model.
module tb_iob_regarray_mp;
    logic        clk = 1'b0;
    logic        cke, rst, we, clear;
    logic [3:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [63:0] rdata_b, rdata_nb, rdata_c;
    logic        busy_b, busy_nb, busy_c;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    iob_regarray_mp #(.RD_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wstrb_i(wstrb),
        .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata_b), .clear_i(clear), .busy_o(busy_b)
    );
    iob_regarray_mp #(.RD_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wstrb_i(wstrb),
        .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata_nb), .clear_i(clear), .busy_o(busy_nb)
    );
    iob_regarray_mp #(.RD_REG(1'b0), .BYPASS(1'b0)) dut_c (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wstrb_i(wstrb),
        .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata_c), .clear_i(clear), .busy_o(busy_c)
    );

    // Reference model
    logic [31:0] mem_m [16];
    logic [31:0] rd_m [2];
    logic [31:0] rdnb_m [2];
    bit          busy_m;
    int          cnt_m;

    typedef struct {
        bit          we;
        logic [3:0]  waddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [3:0]  ra0, ra1;
        logic [31:0] exp0, exp1, exp_nb0;
    } vec_t;
    vec_t vecs [8];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] nw;
        bit acc;
        int a;
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_m[i] = '0;
            rd_m = '{0, 0};
            rdnb_m = '{0, 0};
            busy_m = 0;
            cnt_m = 0;
        end else if (cke) begin
            acc = we && !busy_m;
            nw = merge(mem_m[waddr], wdata, wstrb);
            for (int p = 0; p < 2; p++) begin
                a = int'(raddr[p*4 +: 4]);
                rdnb_m[p] = mem_m[a];
                rd_m[p] = (acc && a == int'(waddr)) ? nw : mem_m[a];
            end
            if (acc) mem_m[waddr] = nw;
            if (busy_m) begin
                mem_m[cnt_m] = '0;
                if (cnt_m == 15) busy_m = 0;
                cnt_m = (cnt_m + 1) % 16;
            end else if (clear) begin
                busy_m = 1;
                cnt_m = 0;
            end
        end
    endtask

    task automatic check_all();
        check("busy_byp", 32'(busy_b), 32'(busy_m));
        check("busy_nobyp", 32'(busy_nb), 32'(busy_m));
        check("busy_comb", 32'(busy_c), 32'(busy_m));
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rd_byp[%0d]", p), rdata_b[p*32 +: 32], rd_m[p]);
            check($sformatf("rd_nobyp[%0d]", p), rdata_nb[p*32 +: 32], rdnb_m[p]);
            check($sformatf("rd_comb[%0d]", p), rdata_c[p*32 +: 32], mem_m[raddr[p*4 +: 4]]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        cke = 1; rst = 0; we = 0; clear = 0; waddr = 0; wstrb = 0; wdata = 0;
    endtask

    task automatic fill_nonzero();
        for (int i = 0; i < 16; i++) begin
            we = 1; waddr = 4'(i); wstrb = 4'hF; wdata = $urandom() | 32'h1;
            tick();
        end
        we = 0;
    endtask

    initial begin
        int n;
        vecs[0] = '{1, 4'd3, 4'hF, 32'hDEADBEEF, 4'd3, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1, 4'd3, 4'h1, 32'h000000AA, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0};
        vecs[2] = '{0, 4'd0, 4'h0, 32'h0, 4'd3, 4'd0, 32'hDEADBEAA, 32'h0, 32'hDEADBEAA};
        vecs[3] = '{1, 4'd5, 4'hF, 32'h11111111, 4'd6, 4'd6, 32'h0, 32'h0, 32'h0};
        vecs[4] = '{1, 4'd5, 4'h3, 32'h00002222, 4'd5, 4'd6, 32'h11112222, 32'h0, 32'h11111111};
        vecs[5] = '{0, 4'd0, 4'h0, 32'h0, 4'd5, 4'd3, 32'h11112222, 32'hDEADBEAA, 32'h11112222};
        vecs[6] = '{1, 4'd7, 4'h0, 32'hFFFFFFFF, 4'd7, 4'd7, 32'h0, 32'h0, 32'h0};
        vecs[7] = '{1, 4'd7, 4'hA, 32'hA1B2C3D4, 4'd7, 4'd5, 32'hA100C300, 32'h11112222, 32'h0};

        idle_inputs();
        raddr = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;

        // Reset state: every address on both ports reads zero
        for (int a = 0; a < 16; a++) begin
            raddr = {4'(15 - a), 4'(a)};
            tick();
        end

        foreach (vecs[i]) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wstrb = vecs[i].wstrb;
            wdata = vecs[i].wdata; raddr = {vecs[i].ra1, vecs[i].ra0};
            tick();
            check($sformatf("vec%0d_p0", i), rdata_b[31:0], vecs[i].exp0);
            check($sformatf("vec%0d_p1", i), rdata_b[63:32], vecs[i].exp1);
            check($sformatf("vec%0d_nb0", i), rdata_nb[31:0], vecs[i].exp_nb0);
        end
        we = 0;

        // Clock-enable low while writing: nothing lands, read registers hold
        we = 1; waddr = 4'd1; wstrb = 4'hF; wdata = 32'hCAFEF00D; cke = 0;
        for (int i = 0; i < 3; i++) begin
            raddr = 8'(i * 17);
            tick();
        end
        cke = 1; we = 0; raddr = 8'h11;
        tick();
        check("cke_nowrite", rdata_b[31:0], 32'h0);

        // Full sweep: busy lasts 16 cycles, dropped write, partial-clear visibility
        fill_nonzero();
        clear = 1;
        tick();
        clear = 0;
        n = 0;
        while (busy_b && n < 50) begin
            we = (n == 4); waddr = 4'd2; wstrb = 4'hF; wdata = 32'h5A5A5A5A;
            raddr = (n == 3) ? 8'hF0 : 8'(n);
            tick();
            n++;
            if (n == 4) begin
                check("mid_entry0", rdata_b[31:0], 32'h0);
                tests_run++;
                if (rdata_b[63:32] == 32'h0) begin
                    tests_failed++;
                    $display("FAIL mid_entry15: got %h expected nonzero", rdata_b[63:32]);
                end
            end
        end
        we = 0;
        check("sweep_len", 32'(n), 32'd16);
        raddr = 8'h02;
        tick();
        check("dropped_write", rdata_b[31:0], 32'h0);

        // Reset on sweep cycle 7 aborts the sweep
        fill_nonzero();
        clear = 1;
        tick();
        clear = 0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1;
        tick();
        check("rst_abort_busy", 32'(busy_b), 32'h0);
        rst = 0;
        we = 1; waddr = 4'd9; wstrb = 4'hF; wdata = 32'h01234567; raddr = 8'h0F;
        tick();
        we = 0; raddr = 8'h09;
        tick();
        check("post_rst_write", rdata_b[31:0], 32'h01234567);
        check("post_rst_clear", rdata_b[63:32], 32'h0);

        // Clock-enable low for 5 cycles mid-sweep stretches it to 21
        fill_nonzero();
        clear = 1;
        tick();
        clear = 0;
        n = 0;
        while (busy_b && n < 60) begin
            cke = !(n >= 3 && n < 8);
            we = 1; waddr = 4'(n); wstrb = 4'hF; wdata = 32'hFFFF0000;
            raddr = 8'($urandom());
            tick();
            n++;
        end
        cke = 1; we = 0;
        check("sweep_len_cke", 32'(n), 32'd21);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            clear = ($urandom_range(0, 39) == 0);
            cke   = ($urandom_range(0, 7) != 0);
            we    = $urandom_range(0, 1) == 1;
            waddr = 4'($urandom());
            wstrb = 4'($urandom());
            wdata = $urandom();
            raddr = 8'($urandom());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
